// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD image controller: loads an image from IROM, edits a window around a movable point, streams it to IRAM.
// Optional build macro LCD_CTRL_RELOAD_EN turns command C into a full image reload from IROM.
module lcd_ctrl_param #(
  parameter int DW    = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int WIN   = 4,
  localparam int AW   = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int N    = IMG_W * IMG_H;
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int HALF = WIN / 2;
  localparam int SH   = 2 * $clog2(WIN);
  localparam int SW   = DW + SH;

  localparam logic [3:0] CMD_WRITE = 4'h0;
  localparam logic [3:0] CMD_UP    = 4'h1;
  localparam logic [3:0] CMD_DOWN  = 4'h2;
  localparam logic [3:0] CMD_LEFT  = 4'h3;
  localparam logic [3:0] CMD_RIGHT = 4'h4;
  localparam logic [3:0] CMD_MAX   = 4'h5;
  localparam logic [3:0] CMD_MIN   = 4'h6;
  localparam logic [3:0] CMD_AVG   = 4'h7;
  localparam logic [3:0] CMD_ROTL  = 4'h8;
  localparam logic [3:0] CMD_ROTR  = 4'h9;
  localparam logic [3:0] CMD_MIRX  = 4'hA;
  localparam logic [3:0] CMD_MIRY  = 4'hB;

  typedef enum logic [2:0] {LOAD, IDLE, EXEC, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] img     [N];
  logic [DW-1:0] img_nxt [N];
  logic [XW-1:0] op_x;
  logic [YW-1:0] op_y;

  logic [AW-1:0] win_addr [WIN][WIN];
  logic [DW-1:0] win      [WIN][WIN];
  logic [DW-1:0] win_new  [WIN][WIN];
  logic [DW-1:0] win_max, win_min, win_avg;
  logic [SW-1:0] win_sum;

  logic accept, reload_cmd, is_win_op, load_last, write_last;

  assign accept     = (state == IDLE) && cmd_valid;
  assign is_win_op  = (cmd >= CMD_MAX) && (cmd <= CMD_MIRY);
  assign load_last  = IROM_rd && (IROM_A == AW'(N - 1));
  assign write_last = (IRAM_A == AW'(N - 1));

`ifdef LCD_CTRL_RELOAD_EN
  localparam logic [3:0] CMD_RELOAD = 4'hC;
  assign reload_cmd = (cmd == CMD_RELOAD);
`else
  assign reload_cmd = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      LOAD:  if (load_last) state_nxt = IDLE;
      IDLE:
        if (cmd_valid) begin
          if (cmd == CMD_WRITE) state_nxt = WRITE;
          else if (reload_cmd)  state_nxt = LOAD;
          else                  state_nxt = EXEC;
        end
      EXEC:  state_nxt = IDLE;
      WRITE: if (write_last) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    done       = (state == DONE);
    IRAM_valid = (state == WRITE);
  end

  // Read enable rises one cycle into LOAD so address 0 is always driven for a full cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IROM_rd <= 1'b0;
      IROM_A  <= '0;
    end else if (state == LOAD) begin
      if (!IROM_rd) begin
        IROM_rd <= 1'b1;
        IROM_A  <= '0;
      end else if (load_last) begin
        IROM_rd <= 1'b0;
      end else begin
        IROM_A <= IROM_A + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IRAM_A <= '0;
      IRAM_D <= '0;
    end else if (accept && (cmd == CMD_WRITE)) begin
      IRAM_A <= '0;
      IRAM_D <= img[0];
    end else if ((state == WRITE) && !write_last) begin
      IRAM_A <= IRAM_A + AW'(1);
      IRAM_D <= img[IRAM_A + AW'(1)];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_x <= XW'(IMG_W / 2);
      op_y <= YW'(IMG_H / 2);
    end else if (accept) begin
      if (reload_cmd) begin
        op_x <= XW'(IMG_W / 2);
        op_y <= YW'(IMG_H / 2);
      end else begin
        case (cmd)
          CMD_UP:    if (op_y > YW'(HALF))         op_y <= op_y - YW'(1);
          CMD_DOWN:  if (op_y < YW'(IMG_H - HALF)) op_y <= op_y + YW'(1);
          CMD_LEFT:  if (op_x > XW'(HALF))         op_x <= op_x - XW'(1);
          CMD_RIGHT: if (op_x < XW'(IMG_W - HALF)) op_x <= op_x + XW'(1);
          default: ;
        endcase
      end
    end
  end

  // Power-of-2 image width lets the pixel address be a plain {row, col} concatenation.
  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_addr[r][c] = {op_y - YW'(HALF) + YW'(r), op_x - XW'(HALF) + XW'(c)};
        win[r][c]      = img[win_addr[r][c]];
      end
    end
  end

  always_comb begin
    win_max = win[0][0];
    win_min = win[0][0];
    win_sum = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if (win[r][c] > win_max) win_max = win[r][c];
        if (win[r][c] < win_min) win_min = win[r][c];
        win_sum = win_sum + SW'(win[r][c]);
      end
    end
    win_avg = DW'(win_sum >> SH);
  end

  always_comb begin
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        win_new[r][c] = win[r][c];
        case (cmd)
          CMD_MAX:  win_new[r][c] = win_max;
          CMD_MIN:  win_new[r][c] = win_min;
          CMD_AVG:  win_new[r][c] = win_avg;
          CMD_ROTL: win_new[r][c] = win[c][WIN-1-r];
          CMD_ROTR: win_new[r][c] = win[WIN-1-c][r];
          CMD_MIRX: win_new[r][c] = win[WIN-1-r][c];
          CMD_MIRY: win_new[r][c] = win[r][WIN-1-c];
          default: ;
        endcase
      end
    end
  end

  // The image array is deliberately left out of reset; LOAD always rewrites every pixel.
  always_comb begin
    img_nxt = img;
    if ((state == LOAD) && IROM_rd) begin
      img_nxt[IROM_A] = IROM_Q;
    end else if (accept && is_win_op) begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++)
          img_nxt[win_addr[r][c]] = win_new[r][c];
    end
  end

  always_ff @(posedge clk) begin
    img <= img_nxt;
  end

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Scoreboard bench for lcd_ctrl_param: a reference image model predicts every IRAM write of each write command.
// Follows LCD_CTRL_RELOAD_EN the same way as the design when modelling command C.
module tb_lcd_ctrl_param;

  localparam int DW    = 8;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int WIN   = 4;
  localparam int N     = IMG_W * IMG_H;
  localparam int AW    = 6;
  localparam int HALF  = WIN / 2;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } sb_t;

  logic          clk;
  logic          reset;
  logic [3:0]    cmd;
  logic          cmd_valid;
  logic          irom_rd;
  logic [AW-1:0] irom_a;
  logic [DW-1:0] irom_q;
  logic          iram_valid;
  logic [DW-1:0] iram_d;
  logic [AW-1:0] iram_a;
  logic          busy;
  logic          done;

  logic [DW-1:0] rom     [N];
  logic [DW-1:0] exp_img [N];
  int            mx, my;
  sb_t           sb_q [$];
  int            checks   = 0;
  int            failures = 0;
  int            load_idx = 0;
  logic          done_next = 1'b0;

  lcd_ctrl_param #(.DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd        (cmd),
    .cmd_valid  (cmd_valid),
    .IROM_rd    (irom_rd),
    .IROM_A     (irom_a),
    .IROM_Q     (irom_q),
    .IRAM_valid (iram_valid),
    .IRAM_D     (iram_d),
    .IRAM_A     (iram_a),
    .busy       (busy),
    .done       (done)
  );

  // IROM data for the driven address is ready by the next rising edge.
  assign irom_q = rom[irom_a];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_apply(input logic [3:0] c);
    logic [DW-1:0] w  [WIN][WIN];
    logic [DW-1:0] nw [WIN][WIN];
    int sum;
    logic [DW-1:0] hi, lo;
    case (c)
      4'h0: for (int k = 0; k < N; k++) sb_q.push_back('{addr: AW'(k), data: exp_img[k]});
      4'h1: if (my > HALF) my--;
      4'h2: if (my < IMG_H - HALF) my++;
      4'h3: if (mx > HALF) mx--;
      4'h4: if (mx < IMG_W - HALF) mx++;
`ifdef LCD_CTRL_RELOAD_EN
      4'hC: begin
        exp_img = rom;
        mx = IMG_W / 2;
        my = IMG_H / 2;
      end
`endif
      4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB: begin
        sum = 0;
        hi  = 0;
        lo  = '1;
        for (int r = 0; r < WIN; r++)
          for (int q = 0; q < WIN; q++) begin
            w[r][q] = exp_img[(my - HALF + r) * IMG_W + (mx - HALF + q)];
            sum += w[r][q];
            if (w[r][q] > hi) hi = w[r][q];
            if (w[r][q] < lo) lo = w[r][q];
          end
        for (int r = 0; r < WIN; r++)
          for (int q = 0; q < WIN; q++) begin
            case (c)
              4'h5: nw[r][q] = hi;
              4'h6: nw[r][q] = lo;
              4'h7: nw[r][q] = DW'(sum / (WIN * WIN));
              4'h8: nw[WIN-1-q][r] = w[r][q];
              4'h9: nw[q][WIN-1-r] = w[r][q];
              4'hA: nw[WIN-1-r][q] = w[r][q];
              default: nw[r][WIN-1-q] = w[r][q];
            endcase
          end
        for (int r = 0; r < WIN; r++)
          for (int q = 0; q < WIN; q++)
            exp_img[(my - HALF + r) * IMG_W + (mx - HALF + q)] = nw[r][q];
      end
      default: ;
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_output("idle_timeout", busy, 0);
  endtask

  // Leaves cmd_valid asserted so the held command also tests that busy cycles ignore it.
  task automatic apply_stimulus(input logic [3:0] c);
    wait_idle();
    cmd       = c;
    cmd_valid = 1'b1;
    model_apply(c);
    @(negedge clk);
    check_output("busy_after_accept", busy, 1);
  endtask

  task automatic check_reset_values();
    check_output("rst_busy", busy, 1);
    check_output("rst_done", done, 0);
    check_output("rst_irom_rd", irom_rd, 0);
    check_output("rst_irom_a", irom_a, 0);
    check_output("rst_iram_valid", iram_valid, 0);
    check_output("rst_iram_d", iram_d, 0);
    check_output("rst_iram_a", iram_a, 0);
  endtask

  task automatic release_and_load();
    int n = 0;
    @(negedge clk);
    reset   = 1'b1;
    exp_img = rom;
    mx      = IMG_W / 2;
    my      = IMG_H / 2;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    check_output("load_cycles", n, 65);
    check_output("irom_rd_after_load", irom_rd, 0);
  endtask

  // Monitor: IROM address walk, IRAM scoreboard, and done timing.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        done_next = 1'b0;
        load_idx  = 0;
      end else begin
        if (irom_rd) begin
          check_output("irom_addr", irom_a, load_idx);
          load_idx++;
        end else begin
          load_idx = 0;
        end
        if (done || done_next) check_output("done", done, done_next);
        done_next = 1'b0;
        if (iram_valid) begin
          if (sb_q.size() == 0) begin
            check_output("unexpected_write", iram_valid, 0);
          end else begin
            e = sb_q.pop_front();
            check_output("iram_addr", iram_a, e.addr);
            check_output("iram_data", iram_d, e.data);
            if (e.addr == AW'(N - 1)) done_next = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] directed [] = '{4'h0,
                                4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h5, 4'h0,
                                4'h2, 4'h2, 4'h4, 4'h4, 4'h7, 4'h0,
                                4'h9, 4'h8, 4'h0,
                                4'hA, 4'hA, 4'hB, 4'hB, 4'h0,
                                4'h9, 4'h0,
                                4'h2, 4'h2, 4'h2, 4'h4, 4'h4, 4'h4, 4'h6, 4'h0,
                                4'hD, 4'hE, 4'hF, 4'h0};
    logic [3:0] c;
    int n;

    reset     = 1'b1;
    cmd       = 4'h0;
    cmd_valid = 1'b0;
    for (int k = 0; k < N; k++) rom[k] = DW'(k);
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    release_and_load();

    foreach (directed[i]) apply_stimulus(directed[i]);

    for (int i = 0; i < 46; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'hC) c = 4'hD;
      apply_stimulus(c);
    end
    apply_stimulus(4'h0);

    // Abort a write part-way through and bring the design back up on a new image.
    apply_stimulus(4'h0);
    n = 0;
    while (!(iram_valid && iram_a == AW'(20)) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check_output("reach_addr20", iram_a, 20);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    sb_q.delete();
    #1;
    check_reset_values();
    @(negedge clk);
    for (int k = 0; k < N; k++) rom[k] = DW'(255 - k);
    release_and_load();
    apply_stimulus(4'h0);
    apply_stimulus(4'h7);
    apply_stimulus(4'h0);

    apply_stimulus(4'h5);
    apply_stimulus(4'hC);
    apply_stimulus(4'h0);

    cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check_output("scoreboard_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
